// File: rtl/pb_debounce_unit_if.sv
// Push-button conditioning bus: raw button input and the three conditioned outputs.
// The master side drives the button; the slave side is the debounce unit.
interface pb_debounce_unit_if;
  logic pb_in;
  logic Clk_out;
  logic pb_level;
  logic pb_out;

  modport master (
    output pb_in,
    input  Clk_out,
    input  pb_level,
    input  pb_out
  );

  modport slave (
    input  pb_in,
    output Clk_out,
    output pb_level,
    output pb_out
  );
endinterface

// File: rtl/pb_debounce_unit.sv
// Clock divider plus tick-sampled push-button debouncer with a single-cycle press pulse.
// Everything runs in the Clk domain; Clk_out is an observation-only square wave.
module pb_debounce_unit #(
  parameter int unsigned COUNTER_DIV    = 250000,
  parameter int unsigned STABLE_SAMPLES = 3
) (
  input  logic               Clk,
  input  logic               Reset,
  pb_debounce_unit_if.slave  bus
);

  localparam logic [24:0] LP_DIV_LAST = 25'(COUNTER_DIV - 1);

  logic [24:0]               r_cnt;
  logic                      r_tick;
  logic                      r_clk_out;
  logic                      r_s1;
  logic                      r_s2;
  logic [STABLE_SAMPLES-1:0] r_shift;
  logic                      r_level;
  logic                      r_pulse;

  logic [24:0]               w_cnt_nxt;
  logic                      w_tick_nxt;
  logic                      w_clk_out_nxt;
  logic [STABLE_SAMPLES-1:0] w_shift_nxt;
  logic                      w_level_nxt;
  logic                      w_pulse_nxt;

  function automatic logic f_all_ones(input logic [STABLE_SAMPLES-1:0] v);
    return &v;
  endfunction

  function automatic logic f_all_zeros(input logic [STABLE_SAMPLES-1:0] v);
    return ~(|v);
  endfunction

  // Next-state: divider wrap, tick-gated sampling, level hysteresis, rising-edge pulse
  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_tick_nxt    = 1'b0;
    w_clk_out_nxt = r_clk_out;
    w_shift_nxt   = r_shift;
    w_level_nxt   = r_level;
    w_pulse_nxt   = 1'b0;

    if (r_cnt == LP_DIV_LAST) begin
      w_cnt_nxt     = 25'd0;
      w_tick_nxt    = 1'b1;
      w_clk_out_nxt = ~r_clk_out;
    end else begin
      w_cnt_nxt     = r_cnt + 25'd1;
      w_tick_nxt    = 1'b0;
      w_clk_out_nxt = r_clk_out;
    end

    if (r_tick) begin
      w_shift_nxt = {r_shift[STABLE_SAMPLES-2:0], r_s2};
    end else begin
      w_shift_nxt = r_shift;
    end

    // A mixed window holds the previous level, which is what rejects bounce
    if (f_all_ones(r_shift)) begin
      w_level_nxt = 1'b1;
    end else if (f_all_zeros(r_shift)) begin
      w_level_nxt = 1'b0;
    end else begin
      w_level_nxt = r_level;
    end

    w_pulse_nxt = w_level_nxt & ~r_level;
  end

  // State registers, all cleared by the asynchronous reset
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_cnt     <= 25'd0;
      r_tick    <= 1'b0;
      r_clk_out <= 1'b0;
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_shift   <= {STABLE_SAMPLES{1'b0}};
      r_level   <= 1'b0;
      r_pulse   <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_tick    <= w_tick_nxt;
      r_clk_out <= w_clk_out_nxt;
      r_s1      <= bus.pb_in;
      r_s2      <= r_s1;
      r_shift   <= w_shift_nxt;
      r_level   <= w_level_nxt;
      r_pulse   <= w_pulse_nxt;
    end
  end

  assign bus.Clk_out  = r_clk_out;
  assign bus.pb_level = r_level;
  assign bus.pb_out   = r_pulse;

endmodule

// File: tb/tb_pb_debounce_unit.sv
// Self-checking bench for pb_debounce_unit: directed press/bounce/reset scenarios plus random
// button activity, every cycle compared against a sample-window reference model.
module tb_pb_debounce_unit;

  localparam int DIV = 4;
  localparam int NS  = 3;

  logic Clk = 1'b0;
  logic Reset;

  pb_debounce_unit_if bus ();

  pb_debounce_unit #(
    .COUNTER_DIV    (DIV),
    .STABLE_SAMPLES (NS)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #10 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: edge count since reset, button history, last NS tick samples
  int e;
  bit hist[$];
  bit smp[$];
  bit m_level;
  bit m_pulse;
  bit m_clk_out;
  int pulses;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  function automatic void model_reset();
    e = 0;
    hist.delete();
    smp.delete();
    for (int i = 0; i < NS; i++) smp.push_back(1'b0);
    m_level   = 1'b0;
    m_pulse   = 1'b0;
    m_clk_out = 1'b0;
  endfunction

  function automatic void model_edge(input bit v);
    int  ones;
    bit  new_level;
    bit  s;
    e++;
    hist.push_back(v);
    ones = 0;
    foreach (smp[i]) ones += int'(smp[i]);
    if (ones == NS)      new_level = 1'b1;
    else if (ones == 0)  new_level = 1'b0;
    else                 new_level = m_level;
    // A tick after edge k*DIV makes edge k*DIV+1 sample the button as it was two edges earlier
    if ((e - 1) >= DIV && ((e - 1) % DIV) == 0) begin
      s = (e >= 3) ? hist[e-3] : 1'b0;
      smp.push_back(s);
      void'(smp.pop_front());
    end
    m_pulse   = new_level & ~m_level;
    m_level   = new_level;
    m_clk_out = ((e / DIV) % 2) == 1;
  endfunction

  task automatic cyc(input bit v);
    bus.pb_in = v;
    @(posedge Clk);
    model_edge(v);
    @(negedge Clk);
    check_eq("clk_out",  int'(bus.Clk_out),  int'(m_clk_out));
    check_eq("pb_level", int'(bus.pb_level), int'(m_level));
    check_eq("pb_out",   int'(bus.pb_out),   int'(m_pulse));
    if (bus.pb_out) pulses++;
  endtask

  task automatic run(input bit v, input int n);
    for (int i = 0; i < n; i++) cyc(v);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_clk_out"},  int'(bus.Clk_out),  0);
    check_eq({tag, "_pb_level"}, int'(bus.pb_level), 0);
    check_eq({tag, "_pb_out"},   int'(bus.pb_out),   0);
  endtask

  initial begin
    int lat;
    Reset     = 1'b0;
    bus.pb_in = 1'b0;
    model_reset();
    pulses = 0;

    // Reset and divider
    repeat (2) begin
      @(negedge Clk);
      check_zero("reset");
    end
    Reset = 1'b1;
    run(1'b0, 12);

    // Clean press with latency bound
    pulses = 0;
    lat    = -1;
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1);
      if (lat < 0 && bus.pb_level) lat = i + 1;
    end
    check_eq("press_latency_le_20", (lat >= 1 && lat <= 20) ? 1 : 0, 1);
    check_eq("press_pulses", pulses, 1);

    // Release, then bounce every 3 cycles and settle high
    pulses = 0;
    run(1'b0, 40);
    check_eq("release_pulses", pulses, 0);
    for (int i = 0; i < 30; i++) cyc(((i / 3) % 2) == 0);
    check_eq("bounce_pulses", pulses, 0);
    run(1'b1, 40);
    check_eq("settle_pulses", pulses, 1);

    // Short glitch from released state
    run(1'b0, 40);
    pulses = 0;
    run(1'b1, 6);
    run(1'b0, 30);
    check_eq("glitch_pulses", pulses, 0);
    check_eq("glitch_level", int'(bus.pb_level), 0);

    // Press, release, re-press
    pulses = 0;
    run(1'b1, 40);
    run(1'b0, 40);
    check_eq("rel_no_pulse", pulses, 1);
    run(1'b1, 40);
    check_eq("repress_pulses", pulses, 2);

    // Asynchronous reset while the level is high
    check_eq("pre_reset_level", int'(bus.pb_level), 1);
    #3 Reset = 1'b0;
    #1 check_zero("async_reset");
    repeat (2) begin
      @(negedge Clk);
      check_zero("held_reset");
    end
    Reset = 1'b1;
    model_reset();
    pulses = 0;
    run(1'b1, 40);
    check_eq("post_reset_pulses", pulses, 1);

    // Random button activity
    for (int blk = 0; blk < 40; blk++) begin
      run(1'($urandom_range(0, 1)), int'($urandom_range(1, 16)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pb_debounce_unit.md
# pb_debounce_unit

Push-button conditioning block for the ALU front panel. It contains a clock divider and a debouncer, both in one `Clk` domain. The divider produces a slow sampling tick and a square-wave `Clk_out`. The debouncer samples a raw, bouncing push-button on each tick and outputs a clean level (`pb_level`) and a single-cycle press pulse (`pb_out`) for the ALU operand/operation entry logic.

## Interface
Parameters:
- `COUNTER_DIV`, default 250000: `Clk` cycles per sampling tick.
  - At 50 MHz the default gives a 200 Hz tick and a 100 Hz `Clk_out`.
  - Counter is 25 bits wide.
  - Legal range is 1..2^25-1.
- `STABLE_SAMPLES`, default 3: number of consecutive identical tick samples needed to change `pb_level`.
  - Legal range is 2..8.

Ports:
- `Clk` in 1: system clock. The only clock; every flop is clocked on its rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `pb_in` in 1: raw push-button, asynchronous to `Clk`, may bounce.
- `Clk_out` out 1: divided square wave. It toggles on every tick, so its period is 2·`COUNTER_DIV` `Clk` cycles. Observation only; never used as a clock.
- `pb_level` out 1: debounced button level.
- `pb_out` out 1: one-`Clk`-cycle pulse on each debounced 0→1 transition of `pb_level`.

## Operation
- Reset (`Reset`=0, asynchronous) clears everything to 0:
  - the divider counter, `tick`, `Clk_out`, the synchronizer flops, the sample shift register, `pb_level` and `pb_out`.
- Divider:
  - `cnt` counts 0..`COUNTER_DIV`-1.
  - On the edge where `cnt`==`COUNTER_DIV`-1: `cnt`←0, `tick`←1 and `Clk_out`←~`Clk_out`.
  - On every other edge: `cnt`←`cnt`+1 and `tick`←0.
  - With `COUNTER_DIV`=1, `tick` is high every cycle after the first edge.
- Synchronizer: `pb_in` passes through two flops (`s1`, `s2`) on every `Clk` edge.
- Sampler:
  - On an edge where `tick`==1, the `STABLE_SAMPLES`-bit shift register shifts in `s2`.
  - When `tick`==0 it holds.
- Level decision, on every edge:
  - If all shift-register bits are 1: `pb_level`←1.
  - If all bits are 0: `pb_level`←0.
  - Otherwise `pb_level` holds (hysteresis).
- Pulse:
  - `pb_out`←1 on the edge where `pb_level` goes 0→1, and 0 on every other edge.
  - `pb_out` is never high for two consecutive cycles.
  - No pulse is produced on release.
- Bounce rejection: any `pb_in` activity shorter than `STABLE_SAMPLES` consecutive tick samples cannot change `pb_level`.
- Button held indefinitely: exactly one `pb_out` pulse.

## Timing
Edges are numbered from the first rising `Clk` edge after `Reset` deasserts (edge 1).
- Divider:
  - `tick` is high after edges k·`COUNTER_DIV`, k≥1, for exactly one cycle.
  - `Clk_out` first rises after edge `COUNTER_DIV` and first falls after edge 2·`COUNTER_DIV`.
- Synchronizer latency: 2 edges.
- Level latency: `pb_level` changes 1 edge after the shift register becomes uniform.
- Pulse latency: `pb_out` is high in the cycle immediately following the edge where `pb_level` rose.
- Worst-case press latency:
  - Assumes `pb_in` is stable from some time t.
  - `pb_level` rises no later than 2 + (`STABLE_SAMPLES`+1)·`COUNTER_DIV` + 2 `Clk` cycles after t.
- Reset asserted mid-operation: all outputs go to 0 immediately (asynchronous) and restart from the reset state; no pulse on deassertion.
- `pb_in` changing on the same edge as a tick: the sample taken is whatever `s2` held before that edge. Metastability is confined to `s1`.

## Test plan
Parameter setting for scenarios 1-5: `COUNTER_DIV`=4, `STABLE_SAMPLES`=3, 20 ns `Clk`.

1. Reset and divider:
   - Stimulus: `Reset`=0 for 2 cycles, then 1, with `pb_in`=0.
   - Response: all outputs 0 during reset; `Clk_out` rises after edge 4, falls after edge 8, period 160 ns; `pb_level`=`pb_out`=0 throughout.
2. Clean press:
   - Stimulus: `pb_in`=1 held for 40 cycles.
   - Response: `pb_level` rises within 20 cycles of the press; `pb_out` high for exactly 1 cycle; no further pulses.
3. Bounce:
   - Stimulus: `pb_in` toggles every 3 cycles for 30 cycles, then settles at 1.
   - Response: exactly one `pb_out` pulse, only after settling; `pb_level` has no glitches.
4. Short glitch:
   - Stimulus: `pb_in`=1 for 6 cycles (at most 2 samples), then 0.
   - Response: `pb_level` and `pb_out` stay 0.
5. Release and re-press:
   - Stimulus: press, then 0 for 40 cycles, then 1 for 40 cycles.
   - Response: `pb_level` falls with no pulse; a second single pulse is produced on the re-press.
6. Reset mid-press:
   - Stimulus: assert `Reset` while `pb_level`=1, release `Reset` with `pb_in`=1.
   - Response: outputs clear asynchronously; `pb_level` re-rises after 3 fresh samples with exactly one new `pb_out` pulse.
